// File: rtl/cache_refill_ctrl.sv
// Miss/refill and write-through controller for a direct-mapped, write-through,
// no-write-allocate cache. It refills whole lines on a load miss and forwards every store to memory.
module cache_refill_ctrl #(
  parameter int LOG_NUM_BLOCKS = 1,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_resp_valid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic                  cache_we,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int NUM_BLOCKS = 1 << LOG_NUM_BLOCKS;
  localparam logic [LOG_NUM_BLOCKS-1:0] LAST_BLOCK = LOG_NUM_BLOCKS'(NUM_BLOCKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WR_MEM,
    FILL_REQ,
    FILL_WAIT,
    DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic                      r_we;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [DATA_WIDTH-1:0]     r_rdata;
  logic [LOG_NUM_BLOCKS-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0]     w_fillAddr;

  // Fill beats always walk the line from block 0 upward, independent of the requested word.
  assign w_fillAddr = {r_addr[ADDR_WIDTH-1:LOG_NUM_BLOCKS], r_cnt};
  assign cpu_rdata  = r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    cpu_req_ready  = (r_state == IDLE) && !rst;
    cpu_resp_valid = 1'b0;
    cache_addr     = r_addr;
    cache_we       = 1'b0;
    cache_wdata    = r_wdata;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_addr       = r_addr;
    mem_wdata      = r_wdata;
    case (r_state)
      IDLE: begin
        if (cpu_req_valid) w_next = LOOKUP;
      end
      LOOKUP: begin
        if (r_we) begin
          // No-write-allocate: a store only updates the cache when the line is already present.
          cache_we = cache_hit;
          w_next   = WR_MEM;
        end else if (cache_hit) begin
          w_next = DONE;
        end else begin
          w_next = FILL_REQ;
        end
      end
      WR_MEM: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        if (mem_req_ready) w_next = DONE;
      end
      FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_addr      = w_fillAddr;
        if (mem_req_ready) w_next = FILL_WAIT;
      end
      FILL_WAIT: begin
        cache_addr = w_fillAddr;
        if (mem_resp_valid) begin
          cache_we    = 1'b1;
          cache_wdata = mem_rdata;
          w_next      = (r_cnt == LAST_BLOCK) ? DONE : FILL_REQ;
        end
      end
      DONE: begin
        cpu_resp_valid = 1'b1;
        w_next         = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu_req_valid) begin
            r_we    <= cpu_req_we;
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
          end
        end
        LOOKUP: begin
          if (!r_we) begin
            if (cache_hit) r_rdata <= cache_rdata;
            else           r_cnt   <= '0;
          end
        end
        FILL_WAIT: begin
          if (mem_resp_valid) begin
            // Capture the requested word as it streams past during the fill.
            if (r_cnt == r_addr[LOG_NUM_BLOCKS-1:0]) r_rdata <= mem_rdata;
            if (r_cnt != LAST_BLOCK) r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: a behavioural word-granular cache sits on the cache port,
// while memory handshakes are driven step by step with hand-computed expected values.
module tb_cache_refill_ctrl;

  logic        clk;
  logic        rst;
  logic        cpuReqValid;
  logic        cpuReqReady;
  logic        cpuReqWe;
  logic [7:0]  cpuAddr;
  logic [31:0] cpuWdata;
  logic        cpuRespValid;
  logic [31:0] cpuRdata;
  logic        cacheHit;
  logic [31:0] cacheRdata;
  logic [7:0]  cacheAddr;
  logic        cacheWe;
  logic [31:0] cacheWdata;
  logic        memReqValid;
  logic        memReqReady;
  logic        memReqWe;
  logic [7:0]  memAddr;
  logic [31:0] memWdata;
  logic        memRespValid;
  logic [31:0] memRdata;

  int vectors;
  int miscompares;

  bit          cacheValid [256];
  logic [31:0] cacheData  [256];

  localparam logic [31:0] WORD_A = 32'hAAAA_0001;
  localparam logic [31:0] WORD_B = 32'hBBBB_0002;
  localparam logic [31:0] WORD_C = 32'hCCCC_0003;
  localparam logic [31:0] WORD_D = 32'hDDDD_0004;

  cache_refill_ctrl #(
    .LOG_NUM_BLOCKS(1),
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req_valid (cpuReqValid),
    .cpu_req_ready (cpuReqReady),
    .cpu_req_we    (cpuReqWe),
    .cpu_addr      (cpuAddr),
    .cpu_wdata     (cpuWdata),
    .cpu_resp_valid(cpuRespValid),
    .cpu_rdata     (cpuRdata),
    .cache_hit     (cacheHit),
    .cache_rdata   (cacheRdata),
    .cache_addr    (cacheAddr),
    .cache_we      (cacheWe),
    .cache_wdata   (cacheWdata),
    .mem_req_valid (memReqValid),
    .mem_req_ready (memReqReady),
    .mem_req_we    (memReqWe),
    .mem_addr      (memAddr),
    .mem_wdata     (memWdata),
    .mem_resp_valid(memRespValid),
    .mem_rdata     (memRdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cache array shares the controller reset, so reset invalidates every word.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) cacheValid[i] <= 1'b0;
    end else if (cacheWe) begin
      cacheValid[cacheAddr] <= 1'b1;
      cacheData[cacheAddr]  <= cacheWdata;
    end
  end

  assign cacheHit   = cacheValid[cacheAddr];
  assign cacheRdata = cacheData[cacheAddr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic we, input logic [7:0] addr,
                               input logic [31:0] wdata);
    cpuReqValid = valid;
    cpuReqWe    = we;
    cpuAddr     = addr;
    cpuWdata    = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst          = 1'b1;
    memReqReady  = 1'b0;
    memRespValid = 1'b0;
    memRdata     = '0;
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_resp_valid", 32'(cpuRespValid), 32'd0);
    checkOutput("rst_cache_we",   32'(cacheWe),      32'd0);
    checkOutput("rst_mem_valid",  32'(memReqValid),  32'd0);
    checkOutput("rst_mem_we",     32'(memReqWe),     32'd0);
    checkOutput("rst_rdata",      cpuRdata,          32'd0);
    checkOutput("rst_ready",      32'(cpuReqReady),  32'd0);
    #3 rst = 1'b0;
    tick();
    checkOutput("post_rst_ready", 32'(cpuReqReady), 32'd1);

    // Reset asserted while a fill is waiting for data
    applyStimulus(1'b1, 1'b0, 8'h11, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    checkOutput("abort_fill_req", 32'(memReqValid), 32'd1);
    memReqReady = 1'b1;
    tick();
    memReqReady  = 1'b0;
    memRespValid = 1'b1;
    memRdata     = 32'h1234_5678;
    #1;
    checkOutput("abort_cache_we_pre", 32'(cacheWe), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_cache_we",   32'(cacheWe),      32'd0);
    checkOutput("abort_mem_valid",  32'(memReqValid),  32'd0);
    checkOutput("abort_resp_valid", 32'(cpuRespValid), 32'd0);
    checkOutput("abort_ready",      32'(cpuReqReady),  32'd0);
    checkOutput("abort_cache_addr", 32'(cacheAddr),    32'd0);
    memRespValid = 1'b0;
    #1 rst = 1'b0;
    tick();
    checkOutput("abort_ready_after", 32'(cpuReqReady), 32'd1);

    // Cold load of 0x11: two-beat refill, requested word is the second beat
    applyStimulus(1'b1, 1'b0, 8'h11, 32'h0);
    #1;
    checkOutput("ld11_ready", 32'(cpuReqReady), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("ld11_lookup_addr", 32'(cacheAddr),   32'h11);
    checkOutput("ld11_lookup_mem",  32'(memReqValid), 32'd0);
    tick();
    checkOutput("ld11_req0_valid", 32'(memReqValid), 32'd1);
    checkOutput("ld11_req0_we",    32'(memReqWe),    32'd0);
    checkOutput("ld11_req0_addr",  32'(memAddr),     32'h10);
    tick();
    checkOutput("ld11_req0_hold", 32'(memAddr), 32'h10);
    memReqReady = 1'b1;
    tick();
    memReqReady = 1'b0;
    checkOutput("ld11_wait0_mem", 32'(memReqValid), 32'd0);
    tick();
    checkOutput("ld11_wait0_idle_we", 32'(cacheWe), 32'd0);
    memRespValid = 1'b1;
    memRdata     = WORD_A;
    #1;
    checkOutput("ld11_beat0_we",    32'(cacheWe),    32'd1);
    checkOutput("ld11_beat0_addr",  32'(cacheAddr),  32'h10);
    checkOutput("ld11_beat0_wdata", cacheWdata,      WORD_A);
    tick();
    memRespValid = 1'b0;
    checkOutput("ld11_req1_addr",  32'(memAddr),     32'h11);
    checkOutput("ld11_req1_valid", 32'(memReqValid), 32'd1);
    memReqReady  = 1'b1;
    memRespValid = 1'b1;
    memRdata     = 32'h0BAD_0BAD;
    #1;
    checkOutput("ld11_sameCycleResp_we", 32'(cacheWe), 32'd0);
    tick();
    memReqReady  = 1'b0;
    memRespValid = 1'b0;
    tick();
    memRespValid = 1'b1;
    memRdata     = WORD_B;
    #1;
    checkOutput("ld11_beat1_we",   32'(cacheWe),   32'd1);
    checkOutput("ld11_beat1_addr", 32'(cacheAddr), 32'h11);
    tick();
    memRespValid = 1'b0;
    checkOutput("ld11_resp",     32'(cpuRespValid), 32'd1);
    checkOutput("ld11_rdata",    cpuRdata,          WORD_B);
    tick();
    checkOutput("ld11_resp_end", 32'(cpuRespValid), 32'd0);
    checkOutput("ld11_idle",     32'(cpuReqReady),  32'd1);

    // Load hit on 0x10: response two cycles after acceptance, no memory traffic
    applyStimulus(1'b1, 1'b0, 8'h10, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("ld10_lookup_resp", 32'(cpuRespValid), 32'd0);
    checkOutput("ld10_lookup_mem",  32'(memReqValid),  32'd0);
    tick();
    checkOutput("ld10_resp",  32'(cpuRespValid), 32'd1);
    checkOutput("ld10_rdata", cpuRdata,          WORD_A);
    checkOutput("ld10_mem",   32'(memReqValid),  32'd0);
    tick();
    checkOutput("ld10_resp_end", 32'(cpuRespValid), 32'd0);

    // Store hit to 0x10 with memory back-pressure for three cycles
    applyStimulus(1'b1, 1'b1, 8'h10, 32'h0000_DEAD);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("st10_cache_we",    32'(cacheWe),   32'd1);
    checkOutput("st10_cache_addr",  32'(cacheAddr), 32'h10);
    checkOutput("st10_cache_wdata", cacheWdata,     32'h0000_DEAD);
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("st10_hold%0d_valid", i), 32'(memReqValid), 32'd1);
      checkOutput($sformatf("st10_hold%0d_we", i),    32'(memReqWe),    32'd1);
      checkOutput($sformatf("st10_hold%0d_addr", i),  32'(memAddr),     32'h10);
      checkOutput($sformatf("st10_hold%0d_wdata", i), memWdata,         32'h0000_DEAD);
      checkOutput($sformatf("st10_hold%0d_resp", i),  32'(cpuRespValid), 32'd0);
      tick();
    end
    memReqReady = 1'b1;
    tick();
    memReqReady = 1'b0;
    checkOutput("st10_resp",     32'(cpuRespValid), 32'd1);
    checkOutput("st10_mem_done", 32'(memReqValid),  32'd0);
    tick();

    applyStimulus(1'b1, 1'b0, 8'h10, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    checkOutput("ld10_after_st_rdata", cpuRdata, 32'h0000_DEAD);
    tick();

    // Store miss to 0x40: memory write only, cache untouched
    applyStimulus(1'b1, 1'b1, 8'h40, 32'h0000_1234);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("st40_cache_we", 32'(cacheWe), 32'd0);
    tick();
    checkOutput("st40_mem_valid", 32'(memReqValid), 32'd1);
    checkOutput("st40_mem_addr",  32'(memAddr),     32'h40);
    checkOutput("st40_mem_wdata", memWdata,         32'h0000_1234);
    checkOutput("st40_wr_cache_we", 32'(cacheWe),   32'd0);
    memReqReady = 1'b1;
    tick();
    memReqReady = 1'b0;
    checkOutput("st40_resp",     32'(cpuRespValid), 32'd1);
    checkOutput("st40_mem_done", 32'(memReqValid),  32'd0);
    tick();

    // Load 0x40 refills the line; a second request is held off until IDLE
    applyStimulus(1'b1, 1'b0, 8'h40, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("ld40_lookup_mem", 32'(memReqValid), 32'd0);
    tick();
    checkOutput("ld40_req0_addr", 32'(memAddr), 32'h40);
    applyStimulus(1'b1, 1'b0, 8'h10, 32'h0);
    #1;
    checkOutput("ld40_busy_ready", 32'(cpuReqReady), 32'd0);
    memReqReady = 1'b1;
    tick();
    memReqReady  = 1'b0;
    memRespValid = 1'b1;
    memRdata     = WORD_C;
    tick();
    memRespValid = 1'b0;
    checkOutput("ld40_req1_addr", 32'(memAddr), 32'h41);
    memReqReady = 1'b1;
    tick();
    memReqReady  = 1'b0;
    memRespValid = 1'b1;
    memRdata     = WORD_D;
    tick();
    memRespValid = 1'b0;
    checkOutput("ld40_resp",       32'(cpuRespValid), 32'd1);
    checkOutput("ld40_rdata",      cpuRdata,          WORD_C);
    checkOutput("ld40_done_ready", 32'(cpuReqReady),  32'd0);
    tick();
    checkOutput("ld40_idle_ready", 32'(cpuReqReady), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("held_req_lookup_addr", 32'(cacheAddr), 32'h10);
    tick();
    checkOutput("held_req_resp",  32'(cpuRespValid), 32'd1);
    checkOutput("held_req_rdata", cpuRdata,          32'h0000_DEAD);
    tick();

    // Spurious memory response while idle must not write the cache
    memRespValid = 1'b1;
    memRdata     = 32'hFFFF_FFFF;
    #1;
    checkOutput("spur_cache_we", 32'(cacheWe), 32'd0);
    tick();
    checkOutput("spur_cache_we_next", 32'(cacheWe),      32'd0);
    checkOutput("spur_resp",          32'(cpuRespValid), 32'd0);
    memRespValid = 1'b0;
    checkOutput("spur_rdata_kept", cpuRdata, 32'h0000_DEAD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
